// File: rtl/ball_motion_engine.sv
// -----------------------------------------------------------------------------
// ball_motion_engine
//
// Moves one square ball for the two-paddle VGA game. The ball advances on a
// divided tick by a step that is latched at serve time. It bounces off the
// side walls and both paddles. A ball that gets past a paddle scores a point
// for the opposite player, and the ball is then frozen for a fixed number of
// ticks before it returns to the serve position.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous, active-low reset
//   start      in   serve request (level), honoured only in IDLE
//   speed      in   pixels per tick, latched at serve, 0 behaves as 1
//   pad_bot_x  in   left x of the bottom paddle
//   pad_top_x  in   left x of the top paddle
//   ball_x     out  ball left x
//   ball_y     out  ball top y
//   state      out  0=IDLE, 1=PLAY, 2=MISS
//   hit        out  one-cycle pulse on a paddle bounce
//   miss_bot   out  one-cycle pulse when the ball passes the bottom paddle
//   miss_top   out  one-cycle pulse when the ball passes the top paddle
//   score_top  out  points won by the top player (saturating)
//   score_bot  out  points won by the bottom player (saturating)
// -----------------------------------------------------------------------------
module ball_motion_engine #(
    parameter int CLK_DIV    = 500_000,
    parameter int XW         = 10,
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int BALL       = 40,
    parameter int PAD_W      = 100,
    parameter int BOT_PAD_Y  = 560,
    parameter int TOP_PAD_Y  = 40,
    parameter int SERVE_X    = 380,
    parameter int SERVE_Y    = 280,
    parameter int HOLD_TICKS = 50,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         speed,
    input  logic [XW-1:0]      pad_bot_x,
    input  logic [XW-1:0]      pad_top_x,
    output logic [XW-1:0]      ball_x,
    output logic [XW-1:0]      ball_y,
    output logic [1:0]         state,
    output logic               hit,
    output logic               miss_bot,
    output logic               miss_top,
    output logic [SCORE_W-1:0] score_top,
    output logic [SCORE_W-1:0] score_bot
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    // Signed coordinate one bit wider than the screen range, so that a
    // step past the left/top edge shows up as a negative value.
    typedef logic signed [XW:0] scoord_t;

    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    localparam scoord_t S_ZERO    = '0;
    localparam scoord_t X_MAX_S   = scoord_t'(H_RES - BALL);
    localparam scoord_t Y_MAX_S   = scoord_t'(V_RES - BALL);
    localparam scoord_t BOT_REST  = scoord_t'(BOT_PAD_Y - BALL);
    localparam scoord_t TOP_REST  = scoord_t'(TOP_PAD_Y);

    localparam logic [XW-1:0] X_MAX_U    = XW'(H_RES - BALL);
    localparam logic [XW-1:0] Y_MAX_U    = XW'(V_RES - BALL);
    localparam logic [XW-1:0] BOT_REST_U = XW'(BOT_PAD_Y - BALL);
    localparam logic [XW-1:0] TOP_REST_U = XW'(TOP_PAD_Y);
    localparam logic [XW-1:0] SERVE_X_U  = XW'(SERVE_X);
    localparam logic [XW-1:0] SERVE_Y_U  = XW'(SERVE_Y);

    localparam logic [XW:0] BALL_W  = (XW+1)'(BALL);
    localparam logic [XW:0] PAD_W_W = (XW+1)'(PAD_W);

    // Registered state
    state_t               state_q;
    logic [CW-1:0]        tick_cnt_q;
    logic [HW-1:0]        hold_cnt_q;
    logic [XW-1:0]        ball_x_q;
    logic [XW-1:0]        ball_y_q;
    logic                 dir_x_q;      // 1 = moving right
    logic                 dir_y_q;      // 1 = moving down
    logic [2:0]           step_q;
    logic                 hit_q;
    logic                 miss_bot_q;
    logic                 miss_top_q;
    logic [SCORE_W-1:0]   score_top_q;
    logic [SCORE_W-1:0]   score_bot_q;

    // Candidate result of one PLAY tick
    logic [XW-1:0]        ball_x_d;
    logic [XW-1:0]        ball_y_d;
    logic                 dir_x_d;
    logic                 dir_y_d;
    logic                 hit_d;
    logic                 miss_bot_d;
    logic                 miss_top_d;

    logic                 tick;
    scoord_t              bx_s;
    scoord_t              by_s;
    scoord_t              step_s;
    scoord_t              nx;
    scoord_t              ny;
    logic [XW:0]          bx_w;
    logic                 overlap_bot;
    logic                 overlap_top;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Geometry of the next tick. Only consumed on the tick cycle, which is
    // also the only time the paddle inputs matter.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        ball_x_d   = '0;
        ball_y_d   = '0;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        hit_d      = 1'b0;
        miss_bot_d = 1'b0;
        miss_top_d = 1'b0;

        bx_s   = $signed({1'b0, ball_x_q});
        by_s   = $signed({1'b0, ball_y_q});
        step_s = $signed({{(XW-2){1'b0}}, step_q});
        nx     = dir_x_q ? (bx_s + step_s) : (bx_s - step_s);
        ny     = dir_y_q ? (by_s + step_s) : (by_s - step_s);

        // Overlap uses the pre-update x; paddles beyond the screen are
        // taken as given, so the sums are kept one bit wider.
        bx_w        = {1'b0, ball_x_q};
        overlap_bot = (bx_w + BALL_W > {1'b0, pad_bot_x}) &&
                      (bx_w < {1'b0, pad_bot_x} + PAD_W_W);
        overlap_top = (bx_w + BALL_W > {1'b0, pad_top_x}) &&
                      (bx_w < {1'b0, pad_top_x} + PAD_W_W);

        // Horizontal: clamp at either wall and reflect.
        ball_x_d = nx[XW-1:0];
        if (nx <= S_ZERO) begin
            ball_x_d = '0;
            dir_x_d  = 1'b1;
        end else if (nx >= X_MAX_S) begin
            ball_x_d = X_MAX_U;
            dir_x_d  = 1'b0;
        end

        // Vertical: a paddle only reflects when this step carries the
        // ball's leading edge across the paddle face; the crossing test is
        // written on ball top y so the comparison stays in range.
        ball_y_d = ny[XW-1:0];
        if (dir_y_q) begin
            if (by_s <= BOT_REST && ny >= BOT_REST && overlap_bot) begin
                ball_y_d = BOT_REST_U;
                dir_y_d  = 1'b0;
                hit_d    = 1'b1;
            end else if (ny >= Y_MAX_S) begin
                ball_y_d   = Y_MAX_U;
                miss_bot_d = 1'b1;
            end
        end else begin
            if (by_s >= TOP_REST && ny <= TOP_REST && overlap_top) begin
                ball_y_d = TOP_REST_U;
                dir_y_d  = 1'b1;
                hit_d    = 1'b1;
            end else if (ny <= S_ZERO) begin
                ball_y_d   = '0;
                miss_top_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; a low pulse on
        // rst_n that ends before the next rising edge is not seen.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            ball_x_q    <= SERVE_X_U;
            ball_y_q    <= SERVE_Y_U;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            step_q      <= 3'd1;
            hit_q       <= 1'b0;
            miss_bot_q  <= 1'b0;
            miss_top_q  <= 1'b0;
            score_top_q <= '0;
            score_bot_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so the
            // pulse defaults below are overridden cleanly by later lines.
            hit_q      <= 1'b0;
            miss_bot_q <= 1'b0;
            miss_top_q <= 1'b0;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_PLAY;
                        tick_cnt_q <= '0;
                        step_q     <= (speed == 3'd0) ? 3'd1 : speed;
                    end
                end

                ST_PLAY: begin
                    if (tick) begin
                        ball_x_q   <= ball_x_d;
                        ball_y_q   <= ball_y_d;
                        dir_x_q    <= dir_x_d;
                        dir_y_q    <= dir_y_d;
                        hit_q      <= hit_d;
                        miss_bot_q <= miss_bot_d;
                        miss_top_q <= miss_top_d;
                        if (miss_bot_d) begin
                            state_q    <= ST_MISS;
                            hold_cnt_q <= '0;
                            if (score_top_q != '1)
                                score_top_q <= score_top_q + SCORE_W'(1);
                        end
                        if (miss_top_d) begin
                            state_q    <= ST_MISS;
                            hold_cnt_q <= '0;
                            if (score_bot_q != '1)
                                score_bot_q <= score_bot_q + SCORE_W'(1);
                        end
                    end
                end

                ST_MISS: begin
                    if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            // dir_y is left as it was at the miss, which
                            // already points toward the player who lost.
                            hold_cnt_q <= '0;
                            ball_x_q   <= SERVE_X_U;
                            ball_y_q   <= SERVE_Y_U;
                            dir_x_q    <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign state     = state_q;
    assign hit       = hit_q;
    assign miss_bot  = miss_bot_q;
    assign miss_top  = miss_top_q;
    assign score_top = score_top_q;
    assign score_bot = score_bot_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// -----------------------------------------------------------------------------
// tb_ball_motion_engine
//
// Scoreboard bench for ball_motion_engine with a short tick (CLK_DIV=4).
// Before every clock edge a reference model computes the expected outputs
// after that edge and pushes them to a queue; after the edge the entry is
// popped and compared with the DUT. Directed checks against fixed numbers
// mark the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_ball_motion_engine;

    localparam int CLK_DIV    = 4;
    localparam int XW         = 10;
    localparam int H_RES      = 800;
    localparam int V_RES      = 600;
    localparam int BALL       = 40;
    localparam int PAD_W      = 100;
    localparam int BOT_PAD_Y  = 560;
    localparam int TOP_PAD_Y  = 40;
    localparam int SERVE_X    = 380;
    localparam int SERVE_Y    = 280;
    localparam int HOLD_TICKS = 50;
    localparam int SCORE_W    = 4;
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [2:0]         speed;
    logic [XW-1:0]      pad_bot_x;
    logic [XW-1:0]      pad_top_x;
    logic [XW-1:0]      ball_x;
    logic [XW-1:0]      ball_y;
    logic [1:0]         state;
    logic               hit;
    logic               miss_bot;
    logic               miss_top;
    logic [SCORE_W-1:0] score_top;
    logic [SCORE_W-1:0] score_bot;

    always #5 clk = ~clk;

    ball_motion_engine #(
        .CLK_DIV    (CLK_DIV),
        .XW         (XW),
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .BALL       (BALL),
        .PAD_W      (PAD_W),
        .BOT_PAD_Y  (BOT_PAD_Y),
        .TOP_PAD_Y  (TOP_PAD_Y),
        .SERVE_X    (SERVE_X),
        .SERVE_Y    (SERVE_Y),
        .HOLD_TICKS (HOLD_TICKS),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .speed     (speed),
        .pad_bot_x (pad_bot_x),
        .pad_top_x (pad_top_x),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .state     (state),
        .hit       (hit),
        .miss_bot  (miss_bot),
        .miss_top  (miss_top),
        .score_top (score_top),
        .score_bot (score_bot)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [63:0] exp_q[$];

    // Reference model state (0=IDLE, 1=PLAY, 2=MISS; directions +1/-1)
    int m_x, m_y, m_dx, m_dy, m_step, m_state;
    int m_hit, m_mb, m_mt, m_st, m_sb, m_cnt, m_hold, m_last_bot;

    // Paddle placement modes: 0 far off-screen, 1 centred under the ball,
    // 2 just clear of the ball's right edge, 3 one pixel under that edge.
    int trk_bot = 1;
    int trk_top = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack(input int x, input int y, input int st,
                                         input int h, input int mb, input int mt,
                                         input int sct, input int scb);
        return 64'({x[XW-1:0], y[XW-1:0], st[1:0], h[0], mb[0], mt[0],
                    sct[SCORE_W-1:0], scb[SCORE_W-1:0]});
    endfunction

    function automatic logic [XW-1:0] pad_for(input int mode, input int x);
        case (mode)
            1:       return (x >= 30) ? XW'(x - 30) : '0;
            2:       return XW'(x + BALL);
            3:       return XW'(x + BALL - 1);
            default: return XW'(1000);
        endcase
    endfunction

    // Expected outputs after the coming clock edge, given current inputs.
    task automatic model_cycle();
        int  nx, ny, ox;
        bit  tck, ov;
        if (!rst_n) begin
            m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = 1; m_step = 1;
            m_state = 0; m_hit = 0; m_mb = 0; m_mt = 0; m_st = 0; m_sb = 0;
            m_cnt = 0; m_hold = 0; m_last_bot = 1;
            return;
        end
        tck   = (m_cnt == CLK_DIV - 1);
        m_cnt = tck ? 0 : m_cnt + 1;
        m_hit = 0; m_mb = 0; m_mt = 0;
        if (m_state == 0) begin
            if (start) begin
                m_state = 1;
                m_cnt   = 0;
                m_step  = (speed == 3'd0) ? 1 : int'(speed);
            end
        end else if (m_state == 1) begin
            if (tck) begin
                ox = m_x;
                nx = m_x + m_dx * m_step;
                if (nx <= 0) begin
                    m_x = 0; m_dx = 1;
                end else if (nx >= H_RES - BALL) begin
                    m_x = H_RES - BALL; m_dx = -1;
                end else begin
                    m_x = nx;
                end
                ny = m_y + m_dy * m_step;
                if (m_dy > 0) begin
                    ov = (ox + BALL > int'(pad_bot_x)) && (ox < int'(pad_bot_x) + PAD_W);
                    if (m_y + BALL <= BOT_PAD_Y && ny + BALL >= BOT_PAD_Y && ov) begin
                        m_y = BOT_PAD_Y - BALL; m_dy = -1; m_hit = 1;
                    end else if (ny >= V_RES - BALL) begin
                        m_y = V_RES - BALL; m_mb = 1; m_state = 2; m_hold = 0;
                        m_last_bot = 1;
                        if (m_st < SCORE_MAX) m_st++;
                    end else begin
                        m_y = ny;
                    end
                end else begin
                    ov = (ox + BALL > int'(pad_top_x)) && (ox < int'(pad_top_x) + PAD_W);
                    if (m_y >= TOP_PAD_Y && ny <= TOP_PAD_Y && ov) begin
                        m_y = TOP_PAD_Y; m_dy = 1; m_hit = 1;
                    end else if (ny <= 0) begin
                        m_y = 0; m_mt = 1; m_state = 2; m_hold = 0;
                        m_last_bot = 0;
                        if (m_sb < SCORE_MAX) m_sb++;
                    end else begin
                        m_y = ny;
                    end
                end
            end
        end else if (tck) begin
            m_hold++;
            if (m_hold == HOLD_TICKS) begin
                m_hold = 0; m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1;
                m_dy = m_last_bot ? 1 : -1;
                m_state = 0;
            end
        end
    endtask

    function automatic logic [63:0] dut_snap();
        return 64'({ball_x, ball_y, state, hit, miss_bot, miss_top, score_top, score_bot});
    endfunction

    // One clock: place paddles, predict, clock, compare after the edge.
    task automatic step();
        pad_bot_x = pad_for(trk_bot, m_x);
        pad_top_x = pad_for(trk_top, m_x);
        model_cycle();
        exp_q.push_back(pack(m_x, m_y, m_state, m_hit, m_mb, m_mt, m_st, m_sb));
        @(posedge clk);
        #1;
        check($sformatf("cyc%0d", cyc), dut_snap(), exp_q.pop_front());
        cyc++;
    endtask

    // Same as step(), with a short rst_n low pulse that ends before the edge.
    task automatic glitch_step();
        pad_bot_x = pad_for(trk_bot, m_x);
        pad_top_x = pad_for(trk_top, m_x);
        model_cycle();
        exp_q.push_back(pack(m_x, m_y, m_state, m_hit, m_mb, m_mt, m_st, m_sb));
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("glitch_cyc%0d", cyc), dut_snap(), exp_q.pop_front());
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic serve(input logic [2:0] spd);
        speed = spd;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; speed = 3'd0;
        pad_bot_x = '0; pad_top_x = '0;
        m_x = SERVE_X; m_y = SERVE_Y;

        // Reset values
        repeat (2) step();
        check("rst_ball_x", 64'(ball_x), 64'(SERVE_X));
        check("rst_ball_y", 64'(ball_y), 64'(SERVE_Y));
        check("rst_state",  64'(state),  64'(0));
        check("rst_pulses", 64'({hit, miss_bot, miss_top}), 64'(0));
        check("rst_scores", 64'({score_top, score_bot}), 64'(0));
        rst_n = 1'b1;
        repeat (3) step();

        // Serve with speed 0: step is 1, first move 4 clocks after PLAY
        serve(3'd0);
        check("play_entry", 64'(state), 64'(1));
        repeat (CLK_DIV - 1) step();
        check("pre_tick_x", 64'(ball_x), 64'(SERVE_X));
        step();
        check("tick1_x", 64'(ball_x), 64'(SERVE_X + 1));
        check("tick1_y", 64'(ball_y), 64'(SERVE_Y + 1));
        // start held high and speed changed mid-play are both ignored
        start = 1'b1; speed = 3'd7;
        repeat (4 * CLK_DIV) step();
        start = 1'b0;
        check("step_kept", 64'(ball_x), 64'(SERVE_X + 5));

        // Speed 5: right wall clamp and reflection
        do_reset();
        trk_bot = 1; trk_top = 1;
        serve(3'd5);
        for (int i = 0; i < 600 && m_x != H_RES - BALL; i++) step();
        check("wall_clamp", 64'(ball_x), 64'(H_RES - BALL));
        check("wall_nohit", 64'(hit), 64'(0));
        repeat (CLK_DIV) step();
        check("wall_back", 64'(ball_x), 64'(H_RES - BALL - 5));

        // Speed 3: bottom paddle bounce, then a miss past the top paddle
        do_reset();
        trk_bot = 1; trk_top = 1;
        serve(3'd3);
        for (int i = 0; i < 600 && m_hit == 0; i++) step();
        check("bot_hit_y",   64'(ball_y), 64'(BOT_PAD_Y - BALL));
        check("bot_hit",     64'(hit), 64'(1));
        check("bot_hit_sc",  64'({score_top, score_bot}), 64'(0));
        step();
        check("hit_pulse_end", 64'(hit), 64'(0));
        repeat (CLK_DIV - 1) step();
        check("bot_hit_up", 64'(ball_y), 64'(BOT_PAD_Y - BALL - 3));
        trk_top = 0;
        for (int i = 0; i < 1500 && m_mt == 0; i++) step();
        check("top_miss",    64'(miss_top), 64'(1));
        check("top_miss_y",  64'(ball_y), 64'(0));
        check("top_miss_sc", 64'(score_bot), 64'(1));
        check("top_miss_st", 64'(state), 64'(2));
        for (int i = 0; i < 400 && m_state != 0; i++) step();
        check("top_serve", 64'({ball_x, ball_y, state}), 64'({10'(SERVE_X), 10'(SERVE_Y), 2'd0}));
        serve(3'd3);
        repeat (CLK_DIV) step();
        check("serve_up", 64'(ball_y), 64'(SERVE_Y - 3));

        // Speed 7: bottom miss just clear of the paddle edge, then saturation
        do_reset();
        trk_bot = 2; trk_top = 1;
        serve(3'd7);
        for (int i = 0; i < 800 && m_mb == 0; i++) step();
        check("bot_miss",    64'(miss_bot), 64'(1));
        check("bot_miss_y",  64'(ball_y), 64'(V_RES - BALL));
        check("bot_miss_sc", 64'(score_top), 64'(1));
        check("bot_miss_st", 64'(state), 64'(2));
        step();
        check("miss_pulse_end", 64'(miss_bot), 64'(0));
        for (int i = 0; i < 400 && m_state != 0; i++) step();
        check("bot_serve", 64'({ball_x, ball_y, state}), 64'({10'(SERVE_X), 10'(SERVE_Y), 2'd0}));
        serve(3'd7);
        repeat (CLK_DIV) step();
        check("serve_down", 64'(ball_y), 64'(SERVE_Y + 7));
        trk_bot = 0;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 800 && m_mb == 0; i++) step();
            for (int i = 0; i < 400 && m_state != 0; i++) step();
            serve(3'd7);
        end
        check("score_sat", 64'(score_top), 64'(SCORE_MAX));

        // Paddle one pixel under the ball's right edge still reflects
        trk_bot = 3;
        for (int i = 0; i < 800 && m_hit == 0; i++) step();
        check("edge_hit",   64'(hit), 64'(1));
        check("edge_hit_y", 64'(ball_y), 64'(BOT_PAD_Y - BALL));

        // Reset pulse between edges is ignored; a sampled one clears all
        glitch_step();
        check("glitch_state", 64'(state), 64'(1));
        check("glitch_score", 64'(score_top), 64'(SCORE_MAX));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_all", dut_snap(),
              64'({10'(SERVE_X), 10'(SERVE_Y), 2'd0, 3'd0, 4'd0, 4'd0}));
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
